// File: rtl/burst_axi_master.sv
`default_nettype none
// ============================================================================
//  Module      : burst_axi_master
//  Description : AXI4 INCR burst master (1..MAX_BURST beats per request).
//                Write beats are streamed in and read beats streamed out over
//                valid/ready handshakes, lane-shifted to/from the AXI bus.
//                Optional stall watchdog enabled by defining AXI_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module burst_axi_master #(
    parameter int DATA_W         = 64,
    parameter int ADDR_W         = 32,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic [1:0]          i_rw,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [2:0]          i_size,
    input  logic [7:0]          i_len,
    input  logic                i_clear,
    output logic                o_wait,
    output logic                o_done,
    output logic                o_error,
    output logic                o_invalid,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_rvalid,
    input  logic                i_rready,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic                m_axi_wlast,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic [1:0]          m_axi_bresp,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    input  logic                m_axi_rlast,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp
`ifdef AXI_TIMEOUT_EN
    ,
    output logic                o_timeout
`endif
);

    localparam int          c_BYTES    = DATA_W / 8;
    localparam int          c_LANE_W   = $clog2(c_BYTES);
    localparam logic [2:0]  c_MAX_SIZE = 3'(c_LANE_W);
    localparam logic [c_BYTES:0] c_ONE = (c_BYTES + 1)'(1);

    localparam logic [1:0]  c_OKAY   = 2'b00;
    localparam logic [1:0]  c_SLVERR = 2'b10;
    localparam logic [1:0]  c_DECERR = 2'b11;

    localparam logic [3:0]  c_ST_IDLE    = 4'd0;
    localparam logic [3:0]  c_ST_DONE    = 4'd1;
    localparam logic [3:0]  c_ST_ERROR   = 4'd2;
    localparam logic [3:0]  c_ST_INVALID = 4'd3;
    localparam logic [3:0]  c_ST_W_ADDR  = 4'd4;
    localparam logic [3:0]  c_ST_W_DATA  = 4'd5;
    localparam logic [3:0]  c_ST_W_RESP  = 4'd6;
    localparam logic [3:0]  c_ST_R_ADDR  = 4'd7;
    localparam logic [3:0]  c_ST_R_DATA  = 4'd8;

    logic [3:0]          r_state;
    logic [3:0]          w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_size;
    logic [7:0]          r_len;
    logic [7:0]          r_beat;
    logic [1:0]          r_resp;

    logic                w_req;
    logic                w_bad;
    logic [7:0]          w_size_mask;
    logic [16:0]         w_span_end;
    logic                w_idle_grp;
    logic                w_last;
    logic [c_LANE_W-1:0] w_offset;
    logic [7:0]          w_nbytes;
    logic [c_BYTES-1:0]  w_lane_mask;
    logic [DATA_W-1:0]   w_byte_mask;
    logic [1:0]          w_rbeat_resp;
    logic                w_accept;
    logic                w_beat_hs;
    logic                w_resp_upd;
    logic                w_complete;
    logic [1:0]          w_final;

    // Severity order: DECERR above SLVERR/EXOKAY above OKAY
    function automatic logic [1:0] f_rank(input logic [1:0] resp);
        return (resp == c_DECERR) ? 2'd2 : ((resp != c_OKAY) ? 2'd1 : 2'd0);
    endfunction

    function automatic logic [1:0] f_worst(input logic [1:0] a, input logic [1:0] b);
        return (f_rank(b) > f_rank(a)) ? b : a;
    endfunction

    // Request legality: alignment, beat size, burst length and 4 KB crossing
    assign w_req       = (i_rw == 2'b01) || (i_rw == 2'b10);
    assign w_size_mask = 8'((9'd1 << i_size) - 9'd1);
    assign w_span_end  = {5'd0, i_addr[11:0]} + (17'({1'b0, i_len} + 9'd1) << i_size);
    assign w_bad       = (|(i_addr[7:0] & w_size_mask))
                      || (i_size > c_MAX_SIZE)
                      || (({1'b0, i_len} + 9'd1) > 9'(MAX_BURST))
                      || (w_span_end > 17'd4096);

    assign w_idle_grp = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE)
                     || (r_state == c_ST_ERROR) || (r_state == c_ST_INVALID);
    assign w_last     = (r_beat == r_len);

    // Byte lane of the current beat and the bytes it occupies
    assign w_offset    = r_addr[c_LANE_W-1:0] + c_LANE_W'({8'd0, r_beat} << r_size);
    assign w_nbytes    = 8'd1 << r_size;
    assign w_lane_mask = c_BYTES'((c_ONE << w_nbytes) - c_ONE);

    genvar gi;
    generate
        for (gi = 0; gi < c_BYTES; gi++) begin : g_byte_mask
            assign w_byte_mask[gi*8 +: 8] = {8{w_lane_mask[gi]}};
        end
    endgenerate

    // A mismatch between the slave's rlast and our own beat count is a slave error
    assign w_rbeat_resp = (m_axi_rlast != w_last) ? f_worst(m_axi_rresp, c_SLVERR) : m_axi_rresp;

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = r_len;
    assign m_axi_awsize  = r_size;
    assign m_axi_awburst = 2'b01;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = r_len;
    assign m_axi_arsize  = r_size;
    assign m_axi_arburst = 2'b01;

`ifdef AXI_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_timeout;
    logic               w_expire;
    logic               w_any_hs;

    assign w_expire = !w_idle_grp && (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_any_hs = (m_axi_awvalid && m_axi_awready) || (m_axi_wvalid && m_axi_wready)
                   || (m_axi_bvalid && m_axi_bready) || (m_axi_arvalid && m_axi_arready)
                   || (m_axi_rvalid && m_axi_rready);
    assign o_timeout = r_timeout;

    // Stall watchdog: restarts on every handshake, idle while no transfer is active
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_idle_grp || w_any_hs || w_expire) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end else if (i_clear || w_accept) begin
                r_timeout <= 1'b0;
            end
        end
    end
`endif

    // Next-state and output decode
    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        w_beat_hs     = 1'b0;
        w_resp_upd    = 1'b0;
        w_complete    = 1'b0;
        w_final       = r_resp;
        o_wait        = 1'b0;
        o_done        = 1'b0;
        o_error       = 1'b0;
        o_invalid     = 1'b0;
        o_wready      = 1'b0;
        o_rvalid      = 1'b0;
        o_rdata       = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_ERROR, c_ST_INVALID: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    if (w_bad) begin
                        w_next    = c_ST_INVALID;
                        o_done    = 1'b1;
                        o_error   = 1'b1;
                        o_invalid = 1'b1;
                    end else begin
                        w_next = (i_rw == 2'b01) ? c_ST_W_ADDR : c_ST_R_ADDR;
                        o_wait = 1'b1;
                    end
                end else if (i_clear) begin
                    w_next = c_ST_IDLE;
                end else begin
                    o_done    = (r_state != c_ST_IDLE);
                    o_error   = (r_state == c_ST_ERROR) || (r_state == c_ST_INVALID);
                    o_invalid = (r_state == c_ST_INVALID);
                end
            end
            c_ST_W_ADDR: begin
                o_wait        = 1'b1;
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) w_next = c_ST_W_DATA;
            end
            c_ST_W_DATA: begin
                o_wait       = 1'b1;
                m_axi_wvalid = i_wvalid;
                o_wready     = m_axi_wready;
                m_axi_wdata  = i_wdata << {w_offset, 3'b000};
                m_axi_wstrb  = w_lane_mask << w_offset;
                m_axi_wlast  = w_last;
                if (i_wvalid && m_axi_wready) begin
                    w_beat_hs = 1'b1;
                    if (w_last) w_next = c_ST_W_RESP;
                end
            end
            c_ST_W_RESP: begin
                o_wait       = 1'b1;
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    w_final    = f_worst(r_resp, m_axi_bresp);
                    w_resp_upd = 1'b1;
                    w_complete = 1'b1;
                end
            end
            c_ST_R_ADDR: begin
                o_wait        = 1'b1;
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) w_next = c_ST_R_DATA;
            end
            c_ST_R_DATA: begin
                o_wait       = 1'b1;
                m_axi_rready = i_rready;
                o_rvalid     = m_axi_rvalid;
                o_rdata      = (m_axi_rdata >> {w_offset, 3'b000}) & w_byte_mask;
                if (m_axi_rvalid && i_rready) begin
                    w_beat_hs  = 1'b1;
                    w_final    = f_worst(r_resp, w_rbeat_resp);
                    w_resp_upd = 1'b1;
                    w_complete = w_last;
                end
            end
            default: w_next = c_ST_IDLE;
        endcase

        if (w_complete) begin
            o_wait    = 1'b0;
            o_done    = 1'b1;
            o_error   = (w_final != c_OKAY);
            o_invalid = (w_final == c_DECERR);
            if (i_clear)                 w_next = c_ST_IDLE;
            else if (w_final == c_DECERR) w_next = c_ST_INVALID;
            else if (w_final != c_OKAY)   w_next = c_ST_ERROR;
            else                          w_next = c_ST_DONE;
        end

`ifdef AXI_TIMEOUT_EN
        if (w_expire) begin
            m_axi_awvalid = 1'b0;
            m_axi_wvalid  = 1'b0;
            m_axi_bready  = 1'b0;
            m_axi_arvalid = 1'b0;
            m_axi_rready  = 1'b0;
            o_wready      = 1'b0;
            o_rvalid      = 1'b0;
            w_beat_hs     = 1'b0;
            w_resp_upd    = 1'b0;
            o_wait        = 1'b0;
            o_done        = 1'b1;
            o_error       = 1'b1;
            o_invalid     = 1'b0;
            w_next        = c_ST_ERROR;
        end
`endif
    end

    // State, request latch, beat counter and sticky response
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= c_ST_IDLE;
            r_addr  <= '0;
            r_size  <= 3'd0;
            r_len   <= 8'd0;
            r_beat  <= 8'd0;
            r_resp  <= c_OKAY;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= i_addr;
                r_size <= i_size;
                r_len  <= i_len;
                r_beat <= 8'd0;
                r_resp <= c_OKAY;
            end
            if (w_beat_hs)  r_beat <= r_beat + 8'd1;
            if (w_resp_upd) r_resp <= w_final;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_burst_axi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_burst_axi_master
//  Description : Directed testbench for burst_axi_master (DATA_W = 64).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_axi_master;

    localparam int DW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          i_rstn, i_clear, i_wvalid, i_rready;
    logic [1:0]    i_rw;
    logic [AW-1:0] i_addr;
    logic [2:0]    i_size;
    logic [7:0]    i_len;
    logic [DW-1:0] i_wdata;
    logic          o_wait, o_done, o_error, o_invalid, o_wready, o_rvalid;
    logic [DW-1:0] o_rdata;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]    m_axi_awlen, m_axi_arlen;
    logic [2:0]    m_axi_awsize, m_axi_arsize;
    logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [7:0]    m_axi_wstrb;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready, m_axi_rlast;
`ifdef AXI_TIMEOUT_EN
    logic          o_timeout;
`endif

    always #5 clk = ~clk;

    burst_axi_master #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(16), .TIMEOUT_CYCLES(1024)) dut (
        .i_clk(clk), .i_rstn(i_rstn), .i_rw(i_rw), .i_addr(i_addr), .i_size(i_size),
        .i_len(i_len), .i_clear(i_clear), .o_wait(o_wait), .o_done(o_done),
        .o_error(o_error), .o_invalid(o_invalid), .i_wdata(i_wdata), .i_wvalid(i_wvalid),
        .o_wready(o_wready), .o_rdata(o_rdata), .o_rvalid(o_rvalid), .i_rready(i_rready),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wlast(m_axi_wlast), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rlast(m_axi_rlast), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
`ifdef AXI_TIMEOUT_EN
        , .o_timeout(o_timeout)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  len;
        logic        exp_wait;
        logic        exp_inv;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        i_rw = 2'b00; i_clear = 1'b0; i_wvalid = 1'b0; i_rready = 1'b0; i_wdata = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00;
    endtask

    task automatic do_reset();
        bus_idle();
        i_rstn = 1'b0;
        tick();
        i_rstn = 1'b1;
    endtask

    task automatic req(input logic [1:0] rw, input logic [31:0] a, input logic [2:0] s, input logic [7:0] l);
        i_rw = rw; i_addr = a; i_size = s; i_len = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rexp [3];
        logic [1:0]  resps [4];
        int k;

        vecs[0] = '{2'b01, 32'h0000_0FF8, 3'd3, 8'd1,  1'b0, 1'b1};
        vecs[1] = '{2'b01, 32'h0000_0003, 3'd2, 8'd0,  1'b0, 1'b1};
        vecs[2] = '{2'b10, 32'h0000_0000, 3'd4, 8'd0,  1'b0, 1'b1};
        vecs[3] = '{2'b10, 32'h0000_0000, 3'd3, 8'd16, 1'b0, 1'b1};
        vecs[4] = '{2'b01, 32'h0000_0F80, 3'd3, 8'd15, 1'b1, 1'b0};
        vecs[5] = '{2'b10, 32'h0000_1004, 3'd2, 8'd0,  1'b1, 1'b0};
        vecs[6] = '{2'b11, 32'h0000_0000, 3'd0, 8'd0,  1'b0, 1'b0};
        vecs[7] = '{2'b01, 32'h0000_0001, 3'd0, 8'd15, 1'b1, 1'b0};
        vecs[8] = '{2'b10, 32'h0000_1FFF, 3'd0, 8'd0,  1'b1, 1'b0};
        vecs[9] = '{2'b10, 32'h0000_1FFF, 3'd0, 8'd1,  1'b0, 1'b1};
        rexp  = '{16'h7654, 16'hBA98, 16'hFEDC};
        resps = '{2'b00, 2'b11, 2'b00, 2'b00};

        i_addr = '0; i_size = '0; i_len = '0;
        bus_idle();
        i_rstn = 1'b0;
        tick();
        tick();
        i_rstn = 1'b1;
        chk("reset_outputs", 64'({o_wait, o_done, o_error, o_invalid, m_axi_awvalid, m_axi_wvalid,
            m_axi_bready, m_axi_arvalid, m_axi_rready, o_wready, o_rvalid}), 64'd0);
        chk("reset_rdata", o_rdata, 64'd0);

        // Request legality table
        for (int i = 0; i < 10; i++) begin
            do_reset();
            req(vecs[i].rw, vecs[i].addr, vecs[i].size, vecs[i].len);
            #1;
            chk($sformatf("vec%0d_wait", i), 64'(o_wait), 64'(vecs[i].exp_wait));
            chk($sformatf("vec%0d_flags", i), 64'({o_done, o_error, o_invalid}),
                64'({3{vecs[i].exp_inv}}));
            tick();
            i_rw = 2'b00;
            #1;
            chk($sformatf("vec%0d_axvalid", i), 64'(m_axi_awvalid | m_axi_arvalid), 64'(vecs[i].exp_wait));
            chk($sformatf("vec%0d_hold", i), 64'({o_done, o_invalid}), 64'({2{vecs[i].exp_inv}}));
        end

        // Write burst: 0x1000, 8-byte beats, 4 beats, OKAY
        do_reset();
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        req(2'b01, 32'h1000, 3'd3, 8'd3);
        tick();
        i_rw = 2'b00;
        #1;
        chk("wr_aw", 64'({m_axi_awvalid, o_wait, m_axi_awburst, m_axi_awsize, m_axi_awlen}),
            64'({1'b1, 1'b1, 2'b01, 3'd3, 8'd3}));
        chk("wr_awaddr", 64'(m_axi_awaddr), 64'h1000);
        tick();
        i_wvalid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            i_wdata = {32'hA5A5_0000 + 32'(b), 32'h0000_1000 + 32'(b)};
            #1;
            chk($sformatf("wr_b%0d_data", b), m_axi_wdata, {32'hA5A5_0000 + 32'(b), 32'h0000_1000 + 32'(b)});
            chk($sformatf("wr_b%0d_ctl", b), 64'({m_axi_wvalid, o_wready, m_axi_wlast, m_axi_wstrb}),
                64'({1'b1, 1'b1, (b == 3), 8'hFF}));
            tick();
        end
        i_wvalid = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        #1;
        chk("wr_complete", 64'({m_axi_bready, o_done, o_error, o_invalid, o_wait}), 64'({5'b11000}));
        tick();
        m_axi_bvalid = 1'b0;
        #1;
        chk("wr_done_hold", 64'({o_done, o_error, o_invalid, o_wait}), 64'({4'b1000}));

        // Unaligned-lane write with user backpressure and SLVERR response
        req(2'b01, 32'h6, 3'd1, 8'd1);
        tick();
        i_rw = 2'b00;
        tick();
        i_wvalid = 1'b0;
        #1;
        chk("wr2_stall", 64'({m_axi_wvalid, o_wait}), 64'({2'b01}));
        tick();
        i_wvalid = 1'b1; i_wdata = 64'hABCD;
        #1;
        chk("wr2_b0", 64'({m_axi_wlast, m_axi_wstrb}), 64'({1'b0, 8'hC0}));
        chk("wr2_b0_data", m_axi_wdata, 64'hABCD_0000_0000_0000);
        tick();
        i_wdata = 64'h1234;
        #1;
        chk("wr2_b1", 64'({m_axi_wlast, m_axi_wstrb}), 64'({1'b1, 8'h03}));
        chk("wr2_b1_data", m_axi_wdata, 64'h1234);
        tick();
        i_wvalid = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
        #1;
        chk("wr2_complete", 64'({o_done, o_error, o_invalid}), 64'({3'b110}));
        tick();
        m_axi_bvalid = 1'b0;
        #1;
        chk("wr2_error_hold", 64'({o_done, o_error, o_invalid}), 64'({3'b110}));

        // Narrow read: 0x2002, 2-byte beats, lane offsets 2/4/6
        do_reset();
        m_axi_arready = 1'b1;
        req(2'b10, 32'h2002, 3'd1, 8'd2);
        tick();
        i_rw = 2'b00;
        #1;
        chk("rd_ar", 64'({m_axi_arvalid, m_axi_arburst, m_axi_arsize, m_axi_arlen}),
            64'({1'b1, 2'b01, 3'd1, 8'd2}));
        chk("rd_araddr", 64'(m_axi_araddr), 64'h2002);
        tick();
        i_rready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 64'hFEDC_BA98_7654_3210;
        for (int b = 0; b < 3; b++) begin
            m_axi_rlast = (b == 2);
            #1;
            chk($sformatf("rd_b%0d_data", b), o_rdata, 64'(rexp[b]));
            chk($sformatf("rd_b%0d_st", b), 64'({o_rvalid, m_axi_rready, o_done, o_error}),
                64'({1'b1, 1'b1, (b == 2), 1'b0}));
            tick();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;

        // Read with DECERR on beat 1 and toggling user ready
        do_reset();
        m_axi_arready = 1'b1;
        req(2'b10, 32'h100, 3'd3, 8'd3);
        tick();
        i_rw = 2'b00;
        tick();
        k = 0;
        for (int c = 0; c < 12 && k < 4; c++) begin
            i_rready = (c % 2 == 0);
            m_axi_rvalid = 1'b1;
            m_axi_rdata = 64'hC0DE_0000_0000_0000 | 64'(k);
            m_axi_rresp = resps[k];
            m_axi_rlast = (k == 3);
            #1;
            if (i_rready) begin
                chk($sformatf("rdc_b%0d_data", k), o_rdata, 64'hC0DE_0000_0000_0000 | 64'(k));
                chk($sformatf("rdc_b%0d_flags", k), 64'({o_done, o_error, o_invalid}),
                    (k == 3) ? 64'd7 : 64'd0);
                k++;
            end else begin
                chk($sformatf("rdc_c%0d_stall", c), 64'({o_rvalid, m_axi_rready, o_done}), 64'({3'b100}));
            end
            tick();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; i_rready = 1'b0;
        #1;
        chk("rdc_invalid_hold", 64'({o_done, o_error, o_invalid, o_wait}), 64'({4'b1110}));
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        #1;
        chk("rdc_cleared", 64'({o_done, o_error, o_invalid, o_wait}), 64'd0);

        // Early rlast on beat 1 of a 4-beat read
        do_reset();
        m_axi_arready = 1'b1;
        req(2'b10, 32'h40, 3'd3, 8'd3);
        tick();
        i_rw = 2'b00;
        tick();
        i_rready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rresp = 2'b00;
        for (int b = 0; b < 4; b++) begin
            m_axi_rlast = (b == 1);
            m_axi_rdata = 64'(b);
            #1;
            chk($sformatf("early_b%0d_done", b), 64'(o_done), 64'(b == 3));
            if (b == 3) chk("early_flags", 64'({o_error, o_invalid}), 64'({2'b10}));
            tick();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; i_rready = 1'b0;

        // Reset in the middle of a write burst
        do_reset();
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        req(2'b01, 32'h0, 3'd3, 8'd3);
        tick();
        i_rw = 2'b00;
        tick();
        i_wvalid = 1'b1; i_wdata = 64'h55;
        #1;
        chk("mid_rst_pre", 64'({m_axi_wvalid, o_wait}), 64'({2'b11}));
        tick();
        i_rstn = 1'b0;
        tick();
        chk("mid_rst_post", 64'({m_axi_wvalid, o_wait, m_axi_awvalid, o_wready, o_done}), 64'd0);
        i_rstn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/burst_axi_master.md
Name: burst_axi_master

Overview:
- Parametrised successor to the single-beat AXI master. Issues one AXI4 INCR burst of 1..MAX_BURST beats per request, with configurable data and address widths.
- Write data is streamed in from the user, and read data is streamed out, each over a valid/ready handshake.
- Sits between a simple command interface (DMA engine, CPU bridge) and an AXI4 interconnect.
- Only one transaction is outstanding at a time.

Parameters:
- DATA_W, 64: AXI and user data width in bits; one of 32, 64, 128.
- ADDR_W, 32: address width in bits.
- MAX_BURST, 16: largest legal beat count; 1..256.
- TIMEOUT_CYCLES, 1024: stall limit. Used only with AXI_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_rw  in  2  00 idle, 01 write, 10 read, 11 reserved (treated as idle)
- i_addr  in  ADDR_W  start address
- i_size  in  3  log2 bytes per beat
- i_len  in  8  beats-1
- i_clear  in  1  clears done/error/invalid
- o_wait  out  1  transaction active
- o_done, o_error, o_invalid  out  1 each  completion status
- i_wdata  in  DATA_W  write beat, LSB-justified
- i_wvalid  in  1  write beat valid
- o_wready  out  1  write beat accepted
- o_rdata  out  DATA_W  read beat, LSB-justified and masked
- o_rvalid  out  1  read beat valid
- i_rready  in  1  read beat accepted
- m_axi_aw{valid,ready,addr[ADDR_W],len[8],size[3],burst[2]}
- m_axi_w{valid,ready,last,data[DATA_W],strb[DATA_W/8]}
- m_axi_b{valid,ready,resp[2]}
- m_axi_ar{valid,ready,addr[ADDR_W],len[8],size[3],burst[2]}
- m_axi_r{valid,ready,last,data[DATA_W],resp[2]}

Behaviour:
- Reset: state IDLE, beat counter 0, sticky response OKAY. All valid/ready outputs, o_wait and status flags are 0; data outputs are 0.
- States: IDLE, DONE, ERROR, INVALID (the idle group), W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA.
- Idle group, i_rw = 01 or 10: latch addr/size/len/rw and run the validity check.
  - Invalid if any of: address not aligned to size; size > log2(DATA_W/8); len+1 > MAX_BURST; addr[11:0] + ((len+1) << size) > 4096 (4 KB boundary crossing).
  - Invalid -> go to INVALID; done/error/invalid assert combinationally that cycle; no AXI activity.
  - Valid -> go to W_ADDR or R_ADDR; o_wait is 1 from that cycle.
- Idle group, i_rw idle: i_clear -> IDLE with flags 0. Otherwise hold, o_done = (state != IDLE), o_error in ERROR/INVALID, o_invalid in INVALID.
- A request takes priority over i_clear in the same cycle.
- AW/AR:
  - valid is asserted the cycle after acceptance and held until ready; addr, len and size are stable while valid.
  - burst = 01 (INCR).
  - No combinational path from ready to valid.
- W_DATA (entered only after the AW handshake):
  - m_axi_wvalid = i_wvalid, o_wready = m_axi_wready (pass-through).
  - Beat lane offset = (start_addr + beat*2^size) mod (DATA_W/8).
  - wdata = i_wdata shifted left by offset*8; wstrb = ((1 << 2^size) - 1) << offset.
  - wlast = 1 on beat len. After the wlast handshake -> W_RESP.
- W_RESP: bready = 1. On bvalid the status is reported and the FSM goes to its final state.
- R_DATA:
  - m_axi_rready = i_rready, o_rvalid = m_axi_rvalid (pass-through).
  - o_rdata = (rdata >> offset*8) masked to 2^size bytes.
  - The last beat is the beat-counter match; m_axi_rlast is checked against it.
  - A mismatch (early rlast, or missing rlast on the final beat) forces an SLVERR-class error. The FSM still completes on the counted final beat.
- Response accumulation: sticky worst-of-beats, with DECERR > SLVERR/EXOKAY > OKAY.
- Completion cycle (B handshake or final R handshake):
  - o_done = 1, o_wait = 0.
  - o_error = (sticky != OKAY), o_invalid = (sticky == DECERR).
  - Next state is IDLE if i_clear, else INVALID, ERROR or DONE per the sticky response.
- Simultaneous events:
  - A new request is accepted only in the idle group; i_rw during an active state is ignored.
  - User backpressure stalls the beat counter; beats are never lost or duplicated.
- Reset mid-burst: all outputs return to reset values on the next edge and the transaction is abandoned. The system resets the slave alongside.

Optional Feature:
- AXI_TIMEOUT_EN defined:
  - A counter runs in any non-idle state and resets on every AW, W, B, AR or R handshake.
  - On reaching TIMEOUT_CYCLES it drops all valid/ready outputs, goes to ERROR, and pulses o_done = o_error = 1 that cycle.
  - Extra output o_timeout (1 bit) is set at expiry and cleared by i_clear or a new request.
- Undefined: no counter and no o_timeout port; the FSM waits indefinitely.

Test Plan:
- Write, DATA_W=64, addr 0x1000, size 3, len 3, slave always ready, bresp OKAY -> awlen=3; 4 W beats with wstrb=0xFF; wlast on beat 3 only; o_done=1, o_error=0; next state DONE.
- Read, addr 0x2002, size 1, len 2 -> lane offsets 2, 4, 6; o_rdata low 16 bits = rdata[31:16], [47:32], [63:48]; upper bits 0.
- Invalid requests:
  - addr 0xFF8, size 3, len 1 (4 KB crossing) -> o_invalid=1 the same cycle; no awvalid ever.
  - addr 0x3, size 2 -> o_invalid=1.
- Read of 4 beats with rresp OKAY, DECERR, OKAY, OKAY and i_rready toggling 1/0 -> all 4 beats delivered in order; final o_error=1, o_invalid=1; state INVALID; i_clear -> flags 0.
- Early rlast on beat 1 of len 3 -> o_error=1, o_invalid=0 at completion after 4 beats. Separately: assert i_rstn=0 mid-W-burst -> wvalid=0 and o_wait=0 on the next edge.
- AXI_TIMEOUT_EN, TIMEOUT_CYCLES=8, awready held 0 -> o_timeout=1, o_error=1 exactly 8 cycles after the last handshake; awvalid drops.
